// File: rtl/intpol2_cfg_sequencer.sv
`timescale 1ns/1ps
// intpol2_cfg_sequencer: host register file for the IQ quadratic interpolator,
// iX^2 shift-add multiplier and core start/completion sequencer.
module intpol2_cfg_sequencer #(
    parameter int DATA_WIDTH = 32,
    parameter int FRAC_BITS  = 31
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      wr_en,
    input  logic [2:0]                wr_addr,
    input  logic [DATA_WIDTH-1:0]     wr_data,
    input  logic [2:0]                rd_addr,
    output logic [DATA_WIDTH-1:0]     rd_data,
    input  logic [7:0]                core_status,
    output logic [4*DATA_WIDTH-1:0]   config_reg,
    output logic                      start,
    output logic                      seq_busy,
    output logic                      irq
);
    localparam int PW    = 2 * DATA_WIDTH;
    localparam int CNT_W = $clog2(DATA_WIDTH);

    typedef enum logic [1:0] {IDLE, CALC, START, RUN} state_t;

    state_t                state;
    logic [DATA_WIDTH-1:0] ix, ilen, ix2;
    logic                  bypass, irq_en;
    logic                  ix2_valid, ix2_sat;
    logic                  done_sticky, err_sticky, abort_sticky;
    logic                  done_prev;
    logic [PW-1:0]         acc, mcand, acc_next;
    logic [DATA_WIDTH-1:0] mplier;
    logic [CNT_W-1:0]      cnt;

    logic wr_ctrl, wr_ix, wr_ilen, wr_status;
    logic go_req, abort_req, idle, done_rise, lock_err, prod_sat, last_step;

    assign wr_ctrl   = wr_en && (wr_addr == 3'd0);
    assign wr_ix     = wr_en && (wr_addr == 3'd1);
    assign wr_ilen   = wr_en && (wr_addr == 3'd2);
    assign wr_status = wr_en && (wr_addr == 3'd3);
    // abort outranks go when both bits arrive in one write
    assign abort_req = wr_ctrl && wr_data[2];
    assign go_req    = wr_ctrl && wr_data[1] && !wr_data[2];
    assign idle      = (state == IDLE);
    assign done_rise = core_status[0] && !done_prev;
    // any non-abort CTRL write (go, bypass, irq_en) is a config attempt while busy
    assign lock_err  = !idle && (wr_ix || wr_ilen || (wr_ctrl && !wr_data[2]));

    assign acc_next  = acc + (mplier[0] ? mcand : '0);
    assign prod_sat  = |(acc_next >> (FRAC_BITS + DATA_WIDTH));
    assign last_step = (cnt == CNT_W'(DATA_WIDTH - 1));

    assign seq_busy   = !idle;
    assign irq        = done_sticky && irq_en;
    assign config_reg = {ilen, ix2, ix, {(DATA_WIDTH-1){1'b0}}, bypass};

    // host-writable configuration, frozen outside IDLE
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ix     <= '0;
            ilen   <= '0;
            bypass <= 1'b0;
            irq_en <= 1'b0;
        end else if (idle) begin
            if (wr_ctrl) begin
                bypass <= wr_data[0];
                irq_en <= wr_data[3];
            end
            if (wr_ix)   ix   <= wr_data;
            if (wr_ilen) ilen <= wr_data;
        end
    end

    // sequencer FSM, iX^2 multiplier and sticky status; sets win over clears
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state        <= IDLE;
            start        <= 1'b0;
            ix2          <= '0;
            ix2_valid    <= 1'b0;
            ix2_sat      <= 1'b0;
            done_sticky  <= 1'b0;
            err_sticky   <= 1'b0;
            abort_sticky <= 1'b0;
            done_prev    <= 1'b0;
            acc          <= '0;
            mcand        <= '0;
            mplier       <= '0;
            cnt          <= '0;
        end else begin
            done_prev <= core_status[0];
            start     <= 1'b0;

            if ((state == RUN) && done_rise && !abort_req)
                done_sticky <= 1'b1;
            else if ((idle && go_req) || (wr_status && wr_data[0]))
                done_sticky <= 1'b0;

            if (lock_err)
                err_sticky <= 1'b1;
            else if ((idle && go_req) || (wr_status && wr_data[2]))
                err_sticky <= 1'b0;

            if (!idle && abort_req)
                abort_sticky <= 1'b1;
            else if ((idle && go_req) || (wr_status && wr_data[3]))
                abort_sticky <= 1'b0;

            if (idle && wr_ix)
                ix2_valid <= 1'b0;

            case (state)
                IDLE: begin
                    if (go_req) begin
                        if (!ix2_valid) begin
                            state  <= CALC;
                            acc    <= '0;
                            mcand  <= PW'(ix);
                            mplier <= ix;
                            cnt    <= '0;
                        end else begin
                            state <= START;
                        end
                    end
                end
                CALC: begin
                    if (abort_req) begin
                        state <= IDLE;
                    end else begin
                        acc    <= acc_next;
                        mcand  <= mcand << 1;
                        mplier <= mplier >> 1;
                        cnt    <= cnt + CNT_W'(1);
                        if (last_step) begin
                            ix2       <= prod_sat ? '1 : acc_next[FRAC_BITS +: DATA_WIDTH];
                            ix2_sat   <= prod_sat;
                            ix2_valid <= 1'b1;
                            state     <= START;
                        end
                    end
                end
                START: begin
                    if (abort_req) begin
                        state <= IDLE;
                    end else begin
                        start <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (abort_req || done_rise)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // combinational register read mux
    always_comb begin
        rd_data = '0;
        case (rd_addr)
            3'd0: begin
                rd_data[0] = bypass;
                rd_data[3] = irq_en;
            end
            3'd1: rd_data = ix;
            3'd2: rd_data = ilen;
            3'd3: begin
                rd_data[0]    = done_sticky;
                rd_data[1]    = seq_busy;
                rd_data[2]    = err_sticky;
                rd_data[3]    = abort_sticky;
                rd_data[4]    = ix2_sat;
                rd_data[5]    = bypass;
                rd_data[6]    = ix2_valid;
                rd_data[15:8] = core_status;
            end
            3'd4: rd_data = ix2;
            default: rd_data = '0;
        endcase
    end
endmodule

// File: tb/tb_intpol2_cfg_sequencer.sv
`timescale 1ns/1ps
// Self-checking bench for intpol2_cfg_sequencer: scenario tasks against a
// register-level model and an arithmetic reference for iX^2.
module tb_intpol2_cfg_sequencer;
    localparam int DW = 32;
    localparam int FB = 31;

    logic            clk = 1'b0;
    logic            rstn;
    logic            wr_en;
    logic [2:0]      wr_addr;
    logic [DW-1:0]   wr_data;
    logic [2:0]      rd_addr;
    logic [DW-1:0]   rd_data;
    logic [7:0]      core_status;
    logic [4*DW-1:0] config_reg;
    logic            start, seq_busy, irq;

    int checks = 0;
    int errors = 0;

    // register-level model
    logic [DW-1:0] m_ix, m_ilen, m_ix2;
    bit m_bypass, m_irqen, m_done, m_err, m_abort, m_sat, m_valid;

    intpol2_cfg_sequencer #(.DATA_WIDTH(DW), .FRAC_BITS(FB)) dut (
        .clk(clk), .rstn(rstn), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr(rd_addr), .rd_data(rd_data), .core_status(core_status),
        .config_reg(config_reg), .start(start), .seq_busy(seq_busy), .irq(irq)
    );

    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // iX^2 in fixed point: full product then drop FB fraction bits, saturating
    function automatic logic [DW-1:0] ref_square(input logic [DW-1:0] x, output bit sat);
        logic [2*DW-1:0] xw, p;
        xw  = x;
        p   = xw * xw;
        sat = (p >> (DW + FB)) != 0;
        return sat ? {DW{1'b1}} : DW'(p >> FB);
    endfunction

    function automatic logic [DW-1:0] exp_status(input bit busy);
        return {16'h0, core_status, 1'b0, m_valid, m_bypass, m_sat, m_abort, m_err, busy, m_done};
    endfunction

    function automatic logic [4*DW-1:0] exp_config();
        return {m_ilen, m_ix2, m_ix, {(DW-1){1'b0}}, m_bypass};
    endfunction

    task automatic model_reset();
        m_ix = '0; m_ilen = '0; m_ix2 = '0;
        m_bypass = 0; m_irqen = 0; m_done = 0; m_err = 0; m_abort = 0; m_sat = 0; m_valid = 0;
    endtask

    task automatic do_write(input logic [2:0] a, input logic [DW-1:0] d);
        @(negedge clk);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic rd(input logic [2:0] a, output logic [DW-1:0] d);
        rd_addr = a;
        #1;
        d = rd_data;
    endtask

    // cycles from the go-sampling edge until start is seen, and pulse width
    task automatic measure_start(output int lat, output int width);
        lat = -1;
        width = 0;
        for (int i = 1; i <= 60; i++) begin
            if (lat < 0) begin
                @(negedge clk);
                if (start) lat = i;
            end
        end
        if (lat > 0) begin
            while (start && width < 8) begin
                width++;
                @(negedge clk);
            end
        end
    endtask

    task automatic core_done();
        core_status[0] = 1'b1;
        @(negedge clk);
        core_status[0] = 1'b0;
    endtask

    task automatic go_write(input bit byp, input bit ien);
        do_write(3'd0, {28'h0, ien, 1'b0, 1'b1, byp});
        m_bypass = byp; m_irqen = ien;
        m_done = 0; m_err = 0; m_abort = 0;
    endtask

    // full computed run: IX/ILEN writes, go, latency, results, core done
    task automatic run_full(input logic [DW-1:0] x, input bit byp, input logic [DW-1:0] len);
        int lat, w;
        bit s;
        logic [DW-1:0] d;
        do_write(3'd1, x);   m_ix = x; m_valid = 0;
        do_write(3'd2, len); m_ilen = len;
        core_status[7:1] = 7'($urandom);
        go_write(byp, 1'b1);
        measure_start(lat, w);
        m_ix2 = ref_square(x, s); m_sat = s; m_valid = 1;
        checks++; if (lat !== 33) begin errors++; $display("FAIL calc_latency ix=%h: got %0d want 33", x, lat); end
        checks++; if (w !== 1) begin errors++; $display("FAIL start_width ix=%h: got %0d want 1", x, w); end
        rd(3'd4, d);
        checks++; if (d !== m_ix2) begin errors++; $display("FAIL ix2 ix=%h: got %h want %h", x, d, m_ix2); end
        rd(3'd3, d);
        checks++; if (d !== exp_status(1)) begin errors++; $display("FAIL status_run ix=%h: got %h want %h", x, d, exp_status(1)); end
        checks++; if (config_reg !== exp_config()) begin errors++; $display("FAIL config_reg: got %h want %h", config_reg, exp_config()); end
        rd(3'd0, d);
        checks++; if (d !== {28'h0, m_irqen, 2'b00, m_bypass}) begin errors++; $display("FAIL ctrl_read: got %h", d); end
        core_done(); m_done = 1;
        checks++; if (seq_busy !== 1'b0) begin errors++; $display("FAIL done_idle: seq_busy got %b want 0", seq_busy); end
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq: got %b want 1", irq); end
    endtask

    task automatic test_reset();
        logic [DW-1:0] d;
        rstn = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; rd_addr = '0; core_status = '0;
        model_reset();
        repeat (3) @(negedge clk);
        checks++; if ({start, seq_busy, irq} !== 3'b000) begin errors++; $display("FAIL reset_outputs: got %b want 000", {start, seq_busy, irq}); end
        checks++; if (config_reg !== '0) begin errors++; $display("FAIL reset_config: got %h want 0", config_reg); end
        rstn = 1'b1;
        for (int a = 0; a < 8; a++) begin
            rd(3'(a), d);
            checks++; if (d !== '0) begin errors++; $display("FAIL reset_read addr %0d: got %h want 0", a, d); end
        end
    endtask

    task automatic test_calc_latency();
        logic [DW-1:0] d;
        run_full(32'h4000_0000, 1'b0, 32'($urandom));
        rd(3'd4, d);
        checks++; if (d !== 32'h2000_0000) begin errors++; $display("FAIL half_squared: got %h want 20000000", d); end
    endtask

    task automatic test_fast_start();
        int lat, w;
        logic [DW-1:0] d;
        go_write(1'b0, 1'b1);
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL go_clears_done: irq got %b want 0", irq); end
        measure_start(lat, w);
        checks++; if (lat !== 1) begin errors++; $display("FAIL fast_latency: got %0d want 1", lat); end
        checks++; if (w !== 1) begin errors++; $display("FAIL fast_width: got %0d want 1", w); end
        core_done(); m_done = 1;
        rd(3'd3, d);
        checks++; if (d !== exp_status(0)) begin errors++; $display("FAIL fast_status: got %h want %h", d, exp_status(0)); end
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL fast_irq: got %b want 1", irq); end
    endtask

    task automatic test_boundaries();
        logic [DW-1:0] d;
        run_full(32'hFFFF_FFFF, 1'b1, 32'h10);
        rd(3'd4, d);
        checks++; if (d !== 32'hFFFF_FFFF) begin errors++; $display("FAIL sat_value: got %h want ffffffff", d); end
        rd(3'd3, d);
        checks++; if (d[4] !== 1'b1) begin errors++; $display("FAIL sat_flag: got %b want 1", d[4]); end
        run_full(32'h8000_0000, 1'b0, 32'h20);
        rd(3'd4, d);
        checks++; if (d !== 32'h8000_0000) begin errors++; $display("FAIL one_squared: got %h want 80000000", d); end
        rd(3'd3, d);
        checks++; if (d[4] !== 1'b0) begin errors++; $display("FAIL one_sat_flag: got %b want 0", d[4]); end
    endtask

    task automatic test_random();
        logic [DW-1:0] x;
        for (int i = 0; i < 8; i++) begin
            case (i % 3)
                0: x = 32'($urandom);
                1: x = 32'($urandom_range(0, 32'h0000_FFFF));
                default: x = 32'h8000_0000 + 32'($urandom_range(0, 32'h00FF_FFFF));
            endcase
            run_full(x, 1'($urandom), 32'($urandom));
        end
    endtask

    task automatic test_config_lock();
        int lat, w;
        bit s;
        logic [DW-1:0] d;
        go_write(m_bypass, 1'b1);
        measure_start(lat, w);
        do_write(3'd1, m_ix ^ 32'h0F0F_0001); m_err = 1;
        rd(3'd1, d);
        checks++; if (d !== m_ix) begin errors++; $display("FAIL ix_locked: got %h want %h", d, m_ix); end
        do_write(3'd2, ~m_ilen);
        rd(3'd2, d);
        checks++; if (d !== m_ilen) begin errors++; $display("FAIL ilen_locked: got %h want %h", d, m_ilen); end
        do_write(3'd0, {28'h0, 1'b0, 2'b00, ~m_bypass});
        checks++; if (config_reg !== exp_config()) begin errors++; $display("FAIL ctrl_locked: got %h want %h", config_reg, exp_config()); end
        rd(3'd3, d);
        checks++; if (d !== exp_status(1)) begin errors++; $display("FAIL lock_err_status: got %h want %h", d, exp_status(1)); end
        core_done(); m_done = 1;
        // go during CALC must neither restart nor shorten the calculation
        do_write(3'd1, 32'h5A5A_1234); m_ix = 32'h5A5A_1234; m_valid = 0;
        go_write(1'b0, 1'b0);
        repeat (4) @(negedge clk);
        do_write(3'd0, 32'h2); m_err = 1;
        measure_start(lat, w);
        m_ix2 = ref_square(m_ix, s); m_sat = s; m_valid = 1;
        checks++; if (lat !== 27) begin errors++; $display("FAIL go_in_calc_latency: got %0d want 27", lat); end
        rd(3'd3, d);
        checks++; if (d !== exp_status(1)) begin errors++; $display("FAIL go_in_calc_status: got %h want %h", d, exp_status(1)); end
        rd(3'd4, d);
        checks++; if (d !== m_ix2) begin errors++; $display("FAIL go_in_calc_ix2: got %h want %h", d, m_ix2); end
        core_done(); m_done = 1;
    endtask

    task automatic test_abort();
        int lat, w, seen;
        logic [DW-1:0] d;
        // abort in RUN
        go_write(1'b0, 1'b1);
        measure_start(lat, w);
        do_write(3'd0, 32'h4); m_abort = 1;
        checks++; if (seq_busy !== 1'b0) begin errors++; $display("FAIL abort_run_idle: seq_busy got %b want 0", seq_busy); end
        rd(3'd3, d);
        checks++; if (d !== exp_status(0)) begin errors++; $display("FAIL abort_run_status: got %h want %h", d, exp_status(0)); end
        // abort and core done rising edge in the same cycle: abort wins
        go_write(1'b0, 1'b1);
        measure_start(lat, w);
        wr_en = 1'b1; wr_addr = 3'd0; wr_data = 32'h4; core_status[0] = 1'b1;
        @(negedge clk);
        wr_en = 1'b0; core_status[0] = 1'b0; m_abort = 1;
        rd(3'd3, d);
        checks++; if (d !== exp_status(0)) begin errors++; $display("FAIL abort_vs_done: got %h want %h", d, exp_status(0)); end
        // STATUS clear coinciding with done being set: set wins
        go_write(1'b0, 1'b1);
        measure_start(lat, w);
        wr_en = 1'b1; wr_addr = 3'd3; wr_data = 32'h1; core_status[0] = 1'b1;
        @(negedge clk);
        wr_en = 1'b0; core_status[0] = 1'b0; m_done = 1;
        rd(3'd3, d);
        checks++; if (d !== exp_status(0)) begin errors++; $display("FAIL clear_vs_done: got %h want %h", d, exp_status(0)); end
        // abort part-way through CALC: no start, no valid result
        do_write(3'd1, 32'($urandom)); m_ix = wr_data; m_valid = 0;
        go_write(1'b0, 1'b0);
        repeat ($urandom_range(1, 30)) @(negedge clk);
        do_write(3'd0, 32'h4); m_abort = 1;
        checks++; if (seq_busy !== 1'b0) begin errors++; $display("FAIL abort_calc_idle: seq_busy got %b want 0", seq_busy); end
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (start) seen++;
        end
        checks++; if (seen !== 0) begin errors++; $display("FAIL abort_calc_no_start: got %0d pulses want 0", seen); end
        rd(3'd3, d);
        checks++; if (d !== exp_status(0)) begin errors++; $display("FAIL abort_calc_status: got %h want %h", d, exp_status(0)); end
        // go and abort together in IDLE: nothing starts, stickies untouched
        do_write(3'd0, 32'h6); m_bypass = 0; m_irqen = 0;
        rd(3'd3, d);
        checks++; if (d !== exp_status(0)) begin errors++; $display("FAIL go_abort_idle: got %h want %h", d, exp_status(0)); end
        // STATUS write-one-to-clear
        do_write(3'd3, 32'hD); m_done = 0; m_err = 0; m_abort = 0;
        rd(3'd3, d);
        checks++; if (d !== exp_status(0)) begin errors++; $display("FAIL status_clear: got %h want %h", d, exp_status(0)); end
    endtask

    task automatic test_reset_mid_calc();
        logic [DW-1:0] d;
        do_write(3'd1, 32'h1234_5678);
        do_write(3'd2, 32'h99);
        go_write(1'b1, 1'b0);
        repeat (10) @(negedge clk);
        checks++; if (seq_busy !== 1'b1) begin errors++; $display("FAIL pre_reset_busy: got %b want 1", seq_busy); end
        #2 rstn = 1'b0;
        #1;
        checks++; if ({start, seq_busy, irq} !== 3'b000) begin errors++; $display("FAIL async_reset_outputs: got %b want 000", {start, seq_busy, irq}); end
        checks++; if (config_reg !== '0) begin errors++; $display("FAIL async_reset_config: got %h want 0", config_reg); end
        core_status = '0;
        @(negedge clk);
        rstn = 1'b1;
        model_reset();
        for (int a = 0; a < 8; a++) begin
            rd(3'(a), d);
            checks++; if (d !== '0) begin errors++; $display("FAIL post_reset_read addr %0d: got %h want 0", a, d); end
        end
    endtask

    initial begin
        test_reset();
        test_calc_latency();
        test_fast_start();
        test_boundaries();
        test_random();
        test_config_lock();
        test_abort();
        test_reset_mid_calc();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/intpol2_cfg_sequencer.md
Name: intpol2_cfg_sequencer

Overview:
Register-mapped configuration and run sequencer for the IQ quadratic interpolator core. It holds the 128-bit config word that feeds the core. It computes iX² from iX with a sequential shift-add multiplier, issues the core start pulse, and tracks core completion. It sits between the host register bus and the core, and locks configuration while a run is in progress.

Parameters:
DATA_WIDTH, 32, register/config word width (iX, iX², ilen)
FRAC_BITS, 31, fractional bits of iX (unsigned Q(DATA_WIDTH-FRAC_BITS).FRAC_BITS)

Ports:
clk  in  1  system clock, all logic on posedge
rstn  in  1  asynchronous active-low reset
wr_en  in  1  register write strobe, one write per cycle
wr_addr  in  3  write address
wr_data  in  DATA_WIDTH  write data
rd_addr  in  3  read address
rd_data  out  DATA_WIDTH  combinational read data
core_status  in  8  core status byte (bit0 done, bit1 busy, bit2 stop_empty, bit3 stop_Afull)
config_reg  out  4*DATA_WIDTH  {ilen, iX2, iX, ctrl0} to the core, ctrl0 bit0 = bypass
start  out  1  one-cycle core start pulse
seq_busy  out  1  high in any state other than IDLE
irq  out  1  done_sticky AND irq_en

Behaviour:
- Register map. 0 CTRL: bit0 bypass, bit1 go (self-clearing, reads 0), bit2 abort (self-clearing), bit3 irq_en. 1 IX. 2 ILEN. 3 STATUS (read-only). 4 IX2 (read-only). 5–7 read 0, writes ignored.
- STATUS bits: 0 done_sticky, 1 seq_busy, 2 err_sticky, 3 abort_sticky, 4 ix2_sat, 5 bypass, 6 ix2_valid, 15:8 core_status. All other bits are 0.
- Reset values: all registers 0, state IDLE, start=0, seq_busy=0, irq=0, config_reg=0, ix2_valid=0. Reset mid-run returns immediately to these values; the multiplier state is discarded.
- Config lock: writes to IX, ILEN or CTRL.bypass/irq_en outside IDLE are ignored and set err_sticky. An IX write in IDLE clears ix2_valid.
- STATUS clearing: a go write clears done_sticky, err_sticky and abort_sticky. A STATUS write of 1 to bit0, 2 or 3 clears that bit; this is allowed in any state.
- FSM states: IDLE, CALC, START, RUN.
- IDLE, go written:
  - If ix2_valid=0 → CALC.
  - Else → START.
- go written outside IDLE: ignored, sets err_sticky.
- CALC: exactly DATA_WIDTH cycles, one multiplier bit per cycle (LSB-first shift-add, 2*DATA_WIDTH accumulator). On the final cycle the IX2 register is loaded, ix2_valid=1, ix2_sat is updated, and the FSM goes to START.
- Latency: go sampled at edge k → CALC edges k+1..k+32 → start=1 during the cycle after edge k+33. With ix2_valid=1, start=1 during the cycle after edge k+1.
- START: start=1 for exactly one cycle, then RUN.
- RUN: exits to IDLE on a rising edge of core_status[0] (edge detector registered from reset, prior value 0). On exit, done_sticky is set.
- Abort write in CALC/START/RUN: → IDLE next edge, abort_sticky set, done_sticky not set, start not issued if still pending. Abort in IDLE: no effect.
- Arithmetic: product = IX*IX unsigned (2*DATA_WIDTH bits). IX2 = product[FRAC_BITS+DATA_WIDTH-1:FRAC_BITS]. If any product bit above that field is 1, IX2 = all-ones and ix2_sat=1; otherwise ix2_sat=0. No rounding (truncate).
- config_reg is a direct register view, stable outside writes. The core sees ilen in the upper word.
- Simultaneous events:
  - An abort in the same cycle as the core done rising edge: abort wins.
  - wr_en with both go and abort set: abort wins, go ignored.
  - A STATUS clear in the same cycle as done_sticky being set: set wins.

Test Plan:
- Reset, then read all addresses → 0. Assert rstn=0 mid-CALC → all outputs 0 asynchronously; seq_busy=0.
- IX=0x4000_0000, go at edge k → start high only in the cycle after edge k+33; IX2=0x2000_0000, ix2_sat=0, ix2_valid=1.
- Second go without an IX write → start one cycle after go. Core done pulse → IDLE, done_sticky=1, irq=1 when irq_en=1.
- IX=0xFFFF_FFFF, go → IX2=0xFFFF_FFFF, ix2_sat=1. IX=0x8000_0000 → IX2=0x8000_0000, ix2_sat=0.
- IX write during RUN → IX unchanged, err_sticky=1. go during CALC → ignored, err_sticky=1.
- Abort in RUN → IDLE next edge, abort_sticky=1, done_sticky=0. Abort in CALC before cycle 32 → no start pulse, ix2_valid stays 0.
